// File: rtl/reg_write_sequencer.sv
// Bus-side sequencer for the write-once lockable configuration register:
// accepts one request, strobes the register on unlocked writes, and answers with status and readback.
module reg_write_sequencer #(
    parameter int unsigned         ADDR_W   = 8,
    parameter int unsigned         DATA_W   = 16,
    parameter logic [ADDR_W-1:0]   REG_ADDR = ADDR_W'('h10)
) (
    input  logic              Clk,
    input  logic              ip_resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              write,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] reg_data_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [7:0]        lock_rejects
);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_LOCKED   = 2'b01;
    localparam logic [1:0] ST_ADDR_ERR = 2'b10;
    localparam logic [1:0] ST_MISMATCH = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    // Data_in doubles as the captured write data: it only changes on a write accept.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            write        <= 1'b0;
            Data_in      <= '0;
            rsp_valid    <= 1'b0;
            rsp_status   <= ST_OK;
            rsp_rdata    <= '0;
            lock_rejects <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_addr != REG_ADDR) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_ADDR_ERR;
                            rsp_rdata  <= '0;
                        end else if (!req_write) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_OK;
                            rsp_rdata  <= reg_data_out;
                        end else if (reg_data_out[0]) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_LOCKED;
                            rsp_rdata  <= reg_data_out;
                            if (lock_rejects != 8'hFF) begin
                                lock_rejects <= lock_rejects + 8'd1;
                            end
                        end else begin
                            state   <= WRITE;
                            write   <= 1'b1;
                            Data_in <= req_wdata;
                        end
                    end
                end
                WRITE: begin
                    write <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    // Readback compares both the payload bits and the lock bit.
                    rsp_rdata  <= reg_data_out;
                    rsp_status <= ((reg_data_out[DATA_W-1:1] == Data_in[DATA_W-1:1]) &&
                                   (reg_data_out[0] == Data_in[0])) ? ST_OK : ST_MISMATCH;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    write     <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Self-checking bench for reg_write_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level model of the sequencer and register.
module tb_reg_write_sequencer;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam logic [7:0]  REG_ADDR = 8'h10;

    logic              Clk;
    logic              ip_resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              write;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] reg_data_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [DATA_W-1:0] rsp_rdata;
    logic [7:0]        lock_rejects;

    // Environment: write-once register with bench-controlled load and readback override.
    logic [DATA_W-1:0] reg_q;
    logic              reg_load;
    logic [DATA_W-1:0] reg_load_val;
    logic              force_en;
    logic [DATA_W-1:0] force_val;

    // Reference state kept at transaction level.
    logic [DATA_W-1:0] mdl_reg;
    int                mdl_rej;

    int total;
    int bad;

    reg_write_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .REG_ADDR(REG_ADDR)
    ) dut (
        .Clk         (Clk),
        .ip_resetn   (ip_resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .write       (write),
        .Data_in     (Data_in),
        .reg_data_out(reg_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_rdata   (rsp_rdata),
        .lock_rejects(lock_rejects)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (reg_load) reg_q <= reg_load_val;
        else if (write && !reg_q[0]) reg_q <= Data_in;
    end

    assign reg_data_out = force_en ? force_val : reg_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input logic [DATA_W-1:0] v);
        @(negedge Clk);
        reg_load     = 1'b1;
        reg_load_val = v;
        @(negedge Clk);
        reg_load = 1'b0;
        mdl_reg  = v;
    endtask

    // One request/response transaction; hold = cycles of response backpressure.
    task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [DATA_W-1:0] wd,
                          input int hold);
        logic [DATA_W-1:0] vis;
        logic [DATA_W-1:0] exp_rd;
        logic [1:0]        exp_st;
        int                exp_lat;
        int                exp_str;
        int                lat;
        int                strobes;
        bit                got;
        vis = force_en ? force_val : mdl_reg;
        if (addr != REG_ADDR) begin
            exp_st = 2'b10; exp_rd = '0; exp_lat = 1; exp_str = 0;
        end else if (!wr) begin
            exp_st = 2'b00; exp_rd = vis; exp_lat = 1; exp_str = 0;
        end else if (vis[0]) begin
            exp_st = 2'b01; exp_rd = vis; exp_lat = 1; exp_str = 0;
            mdl_rej = (mdl_rej >= 255) ? 255 : mdl_rej + 1;
        end else begin
            if (!mdl_reg[0]) mdl_reg = wd;
            exp_rd  = force_en ? force_val : mdl_reg;
            exp_st  = (exp_rd == wd) ? 2'b00 : 2'b11;
            exp_lat = 3;
            exp_str = 1;
        end

        @(negedge Clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = 1'b0;
        lat = 0; strobes = 0; got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge Clk);
            if (c == 1) req_valid = 1'b0;
            if (write) begin
                strobes++;
                check("strobe_data_in", 32'(Data_in), 32'(wd));
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        check("rsp_arrived", 32'(got), 32'd1);
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_status", 32'(rsp_status), 32'(exp_st));
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("strobe_count", 32'(strobes), 32'(exp_str));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_status", 32'(rsp_status), 32'(exp_st));
            check("hold_rdata", 32'(rsp_rdata), 32'(exp_rd));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_no_strobe", 32'(write), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("lock_rejects", 32'(lock_rejects), 32'(mdl_rej));
    endtask

    initial begin
        int pulses;
        int handshakes;
        total = 0; bad = 0;
        ip_resetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        force_en = 1'b0; force_val = '0;
        reg_load = 1'b1; reg_load_val = '0;
        mdl_reg = '0; mdl_rej = 0;
        repeat (3) @(negedge Clk);
        reg_load  = 1'b0;
        ip_resetn = 1'b1;
        @(negedge Clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_write", 32'(write), 32'd0);
        check("rst_data_in", 32'(Data_in), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_lock_rejects", 32'(lock_rejects), 32'd0);

        do_txn(1'b1, REG_ADDR, 16'h1234, 0);
        check("data_in_retained", 32'(Data_in), 32'h1234);

        // Lock then reject
        do_txn(1'b1, REG_ADDR, 16'hABCD, 0);
        do_txn(1'b1, REG_ADDR, 16'h5555, 0);
        check("data_in_after_reject", 32'(Data_in), 32'hABCD);

        // Address error, then read with an overridden readback
        do_txn(1'b1, 8'h20, 16'h7777, 0);
        force_en = 1'b1; force_val = 16'h00F0;
        do_txn(1'b0, REG_ADDR, 16'h0000, 0);

        // Mismatch with 5 cycles of response backpressure
        set_reg(16'h0000);
        force_val = 16'h0000;
        do_txn(1'b1, REG_ADDR, 16'h0002, 5);
        force_en = 1'b0;

        // Saturation: 300 back-to-back locked writes with rsp_ready held high
        set_reg(16'hABCD);
        @(negedge Clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = REG_ADDR; req_wdata = 16'h1111;
        rsp_ready = 1'b1;
        pulses = 0; handshakes = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge Clk);
            if (write) pulses++;
            if (rsp_valid && rsp_ready) handshakes++;
            if (i == 600) begin
                req_valid = 1'b0;
                rsp_ready = 1'b0;
            end
        end
        mdl_rej = (mdl_rej + 300 > 255) ? 255 : mdl_rej + 300;
        check("sat_pulses", 32'(pulses), 32'd0);
        check("sat_handshakes", 32'(handshakes), 32'd300);
        @(negedge Clk);
        check("sat_lock_rejects", 32'(lock_rejects), 32'(mdl_rej));
        check("sat_req_ready", 32'(req_ready), 32'd1);

        // Reset while the write strobe is high
        set_reg(16'h0000);
        @(negedge Clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = REG_ADDR; req_wdata = 16'h0246;
        @(negedge Clk);
        req_valid = 1'b0;
        check("midrst_strobe_up", 32'(write), 32'd1);
        #2 ip_resetn = 1'b0;
        #1;
        check("midrst_write_drop", 32'(write), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_data_in", 32'(Data_in), 32'd0);
        mdl_rej = 0;
        repeat (2) @(negedge Clk);
        ip_resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            check("midrst_no_strobe", 32'(write), 32'd0);
        end
        do_txn(1'b0, REG_ADDR, 16'h0000, 0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            logic              wr;
            logic [7:0]        addr;
            logic [DATA_W-1:0] wd;
            if ($urandom_range(0, 5) == 0) set_reg(DATA_W'($urandom) & 16'hFFFE);
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : REG_ADDR;
            wd   = DATA_W'($urandom);
            wd[0] = ($urandom_range(0, 3) == 0);
            do_txn(wr, addr, wd, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/reg_write_sequencer.md
# reg_write_sequencer

Bus-side front end for the write-once lockable configuration register. Accepts single read/write requests over a valid/ready handshake and decodes the address. Drives the register's one-cycle `write` strobe and `Data_in`, then reads back the register's `Data_out` to confirm the write. Returns a status/readback response over a second valid/ready handshake and counts writes rejected by the lock.

## Interface
- `ADDR_W`, 8: request address width
- `DATA_W`, 16: data width; must match the register
- `REG_ADDR`, 8'h10: address decoded as the write-once register
- `Clk`  in  1: clock, rising edge
- `ip_resetn`  in  1: asynchronous, active-low reset
- `req_valid`  in  1: request present
- `req_ready`  out  1: sequencer can accept a request
- `req_write`  in  1: 1 = write, 0 = read
- `req_addr`  in  ADDR_W: request address
- `req_wdata`  in  DATA_W: write data; bit 0 = lock request
- `write`  out  1: write strobe to the register
- `Data_in`  out  DATA_W: write data to the register
- `reg_data_out`  in  DATA_W: register `Data_out`; bit 0 reflects the lock status while `write`=0
- `rsp_valid`  out  1: response present
- `rsp_ready`  in  1: response consumed
- `rsp_status`  out  2: 00 OK, 01 LOCKED, 10 ADDR_ERR, 11 MISMATCH
- `rsp_rdata`  out  DATA_W: readback value
- `lock_rejects`  out  8: saturating count of LOCKED responses

## Operation
- The sequencer has four states: IDLE, WRITE, SETTLE, RESP. It holds one request in flight; there is no queueing.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture `req_write`, `req_addr` and `req_wdata`.
  - `req_addr`≠REG_ADDR → RESP with ADDR_ERR and rdata=0. No strobe is issued.
  - Read → RESP with OK and rdata=`reg_data_out`.
  - Write with `reg_data_out[0]`=1 (locked) → RESP with LOCKED and rdata=`reg_data_out`. No strobe is issued. `lock_rejects` increments and saturates at 8'hFF.
  - Write with `reg_data_out[0]`=0 → WRITE. `Data_in` loads the captured wdata.
- **WRITE**
  - `write`=1 for exactly one cycle.
  - `Data_in` holds the captured wdata.
  - `reg_data_out` is ignored in this state.
  - Always → SETTLE.
- **SETTLE**
  - `write`=0.
  - Sample `reg_data_out` into rdata.
  - Status: OK if `reg_data_out[DATA_W-1:1]` equals `wdata[DATA_W-1:1]` and `reg_data_out[0]` equals `wdata[0]`; otherwise MISMATCH.
  - Always → RESP.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_status` and `rsp_rdata` are stable until the handshake.
  - On `rsp_ready` → IDLE.
  - `req_ready`=0.
- `req_ready` is 1 only in IDLE. A request and a response are never in the same cycle.
- `Data_in` keeps its last value outside WRITE. It changes only on a write accept.
- Reset (asynchronous, any state):
  - state=IDLE; `write`=0; `Data_in`=0; `rsp_valid`=0; `rsp_status`=00; `rsp_rdata`=0; `lock_rejects`=0.
  - An in-flight request is dropped with no response and no strobe.
  - `req_ready`=1 once reset is released.

## Timing
- Write-accept latency: accept edge at cycle 0; `write` high in cycle 1; sample in cycle 2; `rsp_valid` high in cycle 3.
- Read, LOCKED and ADDR_ERR responses: `rsp_valid` high in cycle 1.
- Back-to-back throughput:
  - With `rsp_ready` held high, a write completes every 4 cycles and other requests every 2 cycles.
  - The next accept happens in the cycle after the response handshake.
- Lock decision: uses `reg_data_out[0]` in the accept cycle only. A lock set by the previous write is visible there because SETTLE precedes it.
- `write` is asserted for exactly one cycle per accepted unlocked write.

## Test plan
- **Reset state:** reset, then write REG_ADDR with 16'h1234 while `reg_data_out`=0.
  - After reset: `req_ready`=1; all outputs 0.
  - `write` pulses once in cycle 1 with `Data_in`=16'h1234.
  - Register model returns 16'h1234 → `rsp_status`=00 and `rsp_rdata`=16'h1234 in cycle 3.
- **Lock then reject:**
  - Write 16'hABCD. The model sets the lock and reads back 16'hABCD → OK.
  - Then write 16'h5555 → LOCKED with `rsp_rdata`=16'hABCD, no `write` pulse, `lock_rejects`=1.
- **Address error and read:**
  - Write to addr 8'h20 → ADDR_ERR with rdata=0 in cycle 1 and no strobe.
  - Read REG_ADDR with `reg_data_out`=16'h00F0 → OK with 16'h00F0.
- **Mismatch and backpressure:**
  - Model forces `reg_data_out`=16'h0000 after a write of 16'h0002 → MISMATCH.
  - Hold `rsp_ready`=0 for 5 cycles: `rsp_valid` and the response fields stay stable and `req_ready`=0.
- **Saturation:** with the register locked, issue 300 writes → `lock_rejects`=8'hFF; zero `write` pulses.
- **Reset mid-write:** assert `ip_resetn`=0 while in WRITE.
  - `write` drops immediately and no response is produced.
  - After release, a new read completes normally.
